// File: rtl/wb_regfile_sb.sv
// Architectural register file with same-cycle writeback bypass and a per-register
// pending-write scoreboard that stalls issue on RAW hazards and counter saturation.
module wb_regfile_sb #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 WRegEn_WB,
  input  logic [DATA_W-1:0]    Dout_WB,
  input  logic [ADDR_W-1:0]    WReg1_WB,
  input  logic [ADDR_W-1:0]    RReg1,
  input  logic [ADDR_W-1:0]    RReg2,
  input  logic                 RdEn1,
  input  logic                 RdEn2,
  input  logic                 Issue_En,
  input  logic                 Issue_WEn,
  input  logic [ADDR_W-1:0]    Issue_WReg,
  output logic [DATA_W-1:0]    Rdata1,
  output logic [DATA_W-1:0]    Rdata2,
  output logic                 Stall,
  output logic [2**ADDR_W-1:0] Busy,
  output logic                 Err
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs  [NREG];
  logic [CNT_W-1:0]  r_cnt   [NREG];
  logic [NREG-1:0]   r_busy;
  logic              r_err;

  logic [CNT_W-1:0]  w_cnt_d [NREG];
  logic [CNT_W-1:0]  w_pend  [NREG];
  logic [NREG-1:0]   w_wbhit;
  logic [NREG-1:0]   w_busy_d;
  logic              w_issue_w;
  logic              w_underflow;

  // A writeback to an idle register does not count as retiring anything, so pend holds at 0.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      w_wbhit[i] = WRegEn_WB && (WReg1_WB == i[ADDR_W-1:0]);
      w_pend[i]  = (w_wbhit[i] && (r_cnt[i] != '0)) ? r_cnt[i] - 1'b1 : r_cnt[i];
    end
  end

  always_comb begin
    Stall = Issue_En && ((RdEn1 && (w_pend[RReg1] != '0)) ||
                         (RdEn2 && (w_pend[RReg2] != '0)) ||
                         (Issue_WEn && (w_pend[Issue_WReg] == '1)));
  end

  assign w_issue_w   = Issue_En && !Stall && Issue_WEn;
  assign w_underflow = WRegEn_WB && (r_cnt[WReg1_WB] == '0);

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      w_cnt_d[i] = r_cnt[i];
      if (w_issue_w && (Issue_WReg == i[ADDR_W-1:0])) begin
        if (!w_wbhit[i]) begin
          w_cnt_d[i] = r_cnt[i] + 1'b1;
        end
      end else if (w_wbhit[i] && (r_cnt[i] != '0)) begin
        w_cnt_d[i] = r_cnt[i] - 1'b1;
      end
      w_busy_d[i] = (w_cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      if (WRegEn_WB) begin
        r_regs[WReg1_WB] <= Dout_WB;
      end
      for (int unsigned i = 0; i < NREG; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
      r_busy <= w_busy_d;
      if (w_underflow) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    Rdata1 = w_wbhit[RReg1] ? Dout_WB : r_regs[RReg1];
    Rdata2 = w_wbhit[RReg2] ? Dout_WB : r_regs[RReg2];
  end

  assign Busy = r_busy;
  assign Err  = r_err;

endmodule
